// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//   Line-granular store queue between the store value unit and the DCache
//   write port. Cache-line-aligned stores (line address, shifted line data,
//   byte mask) are held in a small circular FIFO and drained in allocation
//   order over a valid/ready handshake. A store to the same line as the
//   newest entry is merged into it. A line-address lookup lets the load
//   path stall on pending stores.
//
// Ports
//   clk, rstN                       clock, asynchronous active-low reset
//   enqueueValid/Ready              store request handshake
//   enqueueAddr/Line/Mask           store line address, data, byte mask
//   drainValid/Ready                head entry handshake towards DCache
//   drainAddr/Line/Mask             head entry payload (0 when empty)
//   lookupAddr / lookupHit          pending-store check for loads
//   empty, full                     occupancy status
// -----------------------------------------------------------------------------
module store_buffer #(
    parameter int unsigned LINE_SIZE  = 16,
    parameter int unsigned LINE_WIDTH = LINE_SIZE * 8,
    parameter int unsigned TAG_WIDTH  = 32 - $clog2(LINE_SIZE),
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  enqueueValid,
    output logic                  enqueueReady,
    input  logic [TAG_WIDTH-1:0]  enqueueAddr,
    input  logic [LINE_WIDTH-1:0] enqueueLine,
    input  logic [LINE_SIZE-1:0]  enqueueMask,
    output logic                  drainValid,
    input  logic                  drainReady,
    output logic [TAG_WIDTH-1:0]  drainAddr,
    output logic [LINE_WIDTH-1:0] drainLine,
    output logic [LINE_SIZE-1:0]  drainMask,
    input  logic [TAG_WIDTH-1:0]  lookupAddr,
    output logic                  lookupHit,
    output logic                  empty,
    output logic                  full
);

    localparam int unsigned       PTR_W    = $clog2(DEPTH);
    localparam int unsigned       CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);

    logic [TAG_WIDTH-1:0]  addr_q [DEPTH];
    logic [LINE_WIDTH-1:0] line_q [DEPTH];
    logic [LINE_SIZE-1:0]  mask_q [DEPTH];
    logic [DEPTH-1:0]      valid_q;

    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      newest;

    logic                  push, pop;
    logic                  do_merge, do_alloc;
    logic [LINE_WIDTH-1:0] merge_line;
    logic [DEPTH-1:0]      hit_vec;

    // Status comes from the registered count only; a same-cycle pop does
    // not open a slot for a push.
    assign full         = (count_q == CNT_FULL);
    assign empty        = (count_q == '0);
    assign enqueueReady = !full;
    assign drainValid   = !empty;

    assign push   = enqueueValid && enqueueReady;
    assign pop    = drainValid && drainReady;
    assign newest = tail_q - PTR_ONE;

    // Byte-wise overlay of the incoming store onto the newest entry.
    for (genvar b = 0; b < LINE_SIZE; b++) begin : g_merge_byte
        assign merge_line[b*8 +: 8] = enqueueMask[b] ? enqueueLine[b*8 +: 8]
                                                     : line_q[newest][b*8 +: 8];
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_lookup
        assign hit_vec[g] = valid_q[g] && (addr_q[g] == lookupAddr);
    end
    assign lookupHit = |hit_vec;

    assign drainAddr = drainValid ? addr_q[head_q] : '0;
    assign drainLine = drainValid ? line_q[head_q] : '0;
    assign drainMask = drainValid ? mask_q[head_q] : '0;

    always_comb begin
        do_merge = 1'b0;
        do_alloc = 1'b0;
        // Empty-mask pushes complete the handshake but touch nothing.
        // With a single entry, merging is only safe when that entry cannot
        // leave this cycle, so a ready drain side forces a new allocation.
        if (push && (enqueueMask != '0)) begin
            if ((count_q != '0) && (addr_q[newest] == enqueueAddr) &&
                ((count_q > CNT_ONE) || !drainReady)) begin
                do_merge = 1'b1;
            end else begin
                do_alloc = 1'b1;
            end
        end

        head_d  = pop      ? head_q + PTR_ONE : head_q;
        tail_d  = do_alloc ? tail_q + PTR_ONE : tail_q;
        count_d = count_q;
        case ({do_alloc, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Pop and allocate never target the same slot: allocation needs
    // count < DEPTH, so tail differs from a valid head. A merge with a
    // single entry only happens when no pop occurs.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            valid_q <= '0;
            addr_q  <= '{default: '0};
            line_q  <= '{default: '0};
            mask_q  <= '{default: '0};
        end else begin
            if (pop) begin
                valid_q[head_q] <= 1'b0;
            end
            if (do_alloc) begin
                valid_q[tail_q] <= 1'b1;
                addr_q[tail_q]  <= enqueueAddr;
                line_q[tail_q]  <= enqueueLine;
                mask_q[tail_q]  <= enqueueMask;
            end
            if (do_merge) begin
                line_q[newest] <= merge_line;
                mask_q[newest] <= mask_q[newest] | enqueueMask;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
//   Directed bench for store_buffer with the default geometry
//   (16-byte lines, 28-bit line address, 4 entries).
// -----------------------------------------------------------------------------
module tb_store_buffer;

    localparam int unsigned LS = 16;
    localparam int unsigned LW = 128;
    localparam int unsigned TW = 28;

    logic          clk = 1'b0;
    logic          rstN;
    logic          enqueueValid;
    logic          enqueueReady;
    logic [TW-1:0] enqueueAddr;
    logic [LW-1:0] enqueueLine;
    logic [LS-1:0] enqueueMask;
    logic          drainValid;
    logic          drainReady;
    logic [TW-1:0] drainAddr;
    logic [LW-1:0] drainLine;
    logic [LS-1:0] drainMask;
    logic [TW-1:0] lookupAddr;
    logic          lookupHit;
    logic          empty;
    logic          full;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [TW-1:0] expq [$];
    logic [TW-1:0] exp_addr;

    store_buffer #(
        .LINE_SIZE (LS),
        .DEPTH     (4)
    ) dut (
        .clk          (clk),
        .rstN         (rstN),
        .enqueueValid (enqueueValid),
        .enqueueReady (enqueueReady),
        .enqueueAddr  (enqueueAddr),
        .enqueueLine  (enqueueLine),
        .enqueueMask  (enqueueMask),
        .drainValid   (drainValid),
        .drainReady   (drainReady),
        .drainAddr    (drainAddr),
        .drainLine    (drainLine),
        .drainMask    (drainMask),
        .lookupAddr   (lookupAddr),
        .lookupHit    (lookupHit),
        .empty        (empty),
        .full         (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [TW-1:0] a, input logic [7:0] b0,
                         input logic [LS-1:0] m, input logic rdy);
        enqueueValid = v;
        enqueueAddr  = a;
        enqueueLine  = {{(LW-8){1'b0}}, b0};
        enqueueMask  = m;
        drainReady   = rdy;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstN         = 1'b0;
        drive(1'b0, '0, 8'h00, '0, 1'b0);
        lookupAddr   = 28'h0000010;
        tick();
        tick();
        // Reset state
        check("rst_drainValid", LW'(drainValid), LW'(0));
        check("rst_enqReady", LW'(enqueueReady), LW'(1));
        check("rst_empty", LW'(empty), LW'(1));
        check("rst_full", LW'(full), LW'(0));
        check("rst_hit", LW'(lookupHit), LW'(0));
        check("rst_drainAddr", LW'(drainAddr), LW'(0));
        check("rst_drainLine", drainLine, LW'(0));
        check("rst_drainMask", LW'(drainMask), LW'(0));
        rstN = 1'b1;
        tick();

        // First push, no bypass: drainValid only the next cycle
        drive(1'b1, 28'h0000010, 8'hAA, 16'h0001, 1'b0);
        #1;
        check("p1_noBypass", LW'(drainValid), LW'(0));
        tick();
        enqueueValid = 1'b0;
        #1;
        check("p1_drainValid", LW'(drainValid), LW'(1));
        check("p1_drainAddr", LW'(drainAddr), LW'(28'h0000010));
        check("p1_drainMask", LW'(drainMask), LW'(16'h0001));
        check("p1_hit", LW'(lookupHit), LW'(1));
        lookupAddr = 28'h0000011;
        #1;
        check("p1_miss", LW'(lookupHit), LW'(0));

        // Merge into single entry while drain side stalled
        enqueueValid = 1'b1;
        enqueueAddr  = 28'h0000010;
        enqueueLine  = {{(LW-16){1'b0}}, 16'hBB00};
        enqueueMask  = 16'h0002;
        tick();
        enqueueValid = 1'b0;
        #1;
        check("m1_drainMask", LW'(drainMask), LW'(16'h0003));
        check("m1_bytes", LW'(drainLine[15:0]), LW'(16'hBBAA));

        // Same address with drainReady=1: head leaves, a new entry is allocated
        enqueueValid = 1'b1;
        enqueueLine  = {{(LW-24){1'b0}}, 24'hCC0000};
        enqueueMask  = 16'h0004;
        drainReady   = 1'b1;
        #1;
        check("m2_poppedMask", LW'(drainMask), LW'(16'h0003));
        tick();
        enqueueValid = 1'b0;
        drainReady   = 1'b0;
        #1;
        check("m2_newValid", LW'(drainValid), LW'(1));
        check("m2_newMask", LW'(drainMask), LW'(16'h0004));
        check("m2_newLine", drainLine, LW'(24'hCC0000));
        drainReady = 1'b1;
        tick();
        drainReady = 1'b0;
        #1;
        check("m2_countOne", LW'(empty), LW'(1));

        // Fill four distinct lines
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, TW'(k), 8'(k), 16'h0001, 1'b0);
            tick();
        end
        enqueueValid = 1'b0;
        #1;
        check("f_full", LW'(full), LW'(1));
        check("f_enqReady", LW'(enqueueReady), LW'(0));
        // Would-merge push while full is rejected
        drive(1'b1, 28'h0000004, 8'hEE, 16'h0003, 1'b0);
        tick();
        enqueueValid = 1'b0;
        drainReady   = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            #1;
            check("f_drainAddr", LW'(drainAddr), LW'(k));
            check("f_drainByte", LW'(drainLine[7:0]), LW'(k));
            check("f_drainMask", LW'(drainMask), LW'(16'h0001));
            tick();
        end
        check("f_emptyAfter", LW'(empty), LW'(1));
        check("f_validAfter", LW'(drainValid), LW'(0));

        // Fill, hold full, then steady push+pop streaming with wrap
        expq.delete();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, TW'(32 + k), 8'h11, 16'h0001, 1'b0);
            expq.push_back(TW'(32 + k));
            tick();
        end
        enqueueValid = 1'b0;
        tick();
        check("s_holdFull", LW'(full), LW'(1));
        drainReady = 1'b1;
        #1;
        exp_addr = expq.pop_front();
        check("s_pop0", LW'(drainAddr), LW'(exp_addr));
        tick();
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, TW'(48 + k), 8'h22, 16'h0001, 1'b1);
            #1;
            check("s_enqReady", LW'(enqueueReady), LW'(1));
            exp_addr = expq.pop_front();
            check("s_drainAddr", LW'(drainAddr), LW'(exp_addr));
            expq.push_back(TW'(48 + k));
            tick();
            check("s_notFull", LW'(full), LW'(0));
            check("s_notEmpty", LW'(empty), LW'(0));
        end
        enqueueValid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            exp_addr = expq.pop_front();
            check("s_tailDrain", LW'(drainAddr), LW'(exp_addr));
            tick();
        end
        check("s_emptyEnd", LW'(empty), LW'(1));

        // Empty-mask push: accepted, discarded
        drive(1'b1, 28'h0000077, 8'h99, 16'h0000, 1'b0);
        lookupAddr = 28'h0000077;
        #1;
        check("z_enqReady", LW'(enqueueReady), LW'(1));
        tick();
        enqueueValid = 1'b0;
        #1;
        check("z_empty", LW'(empty), LW'(1));
        check("z_drainValid", LW'(drainValid), LW'(0));
        check("z_hit", LW'(lookupHit), LW'(0));

        // Asynchronous reset mid-operation
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, TW'(64 + k), 8'h33, 16'h0001, 1'b0);
            tick();
        end
        enqueueValid = 1'b0;
        lookupAddr   = 28'h0000040;
        drainReady   = 1'b1;
        #1;
        check("r_preHit", LW'(lookupHit), LW'(1));
        #1;
        rstN = 1'b0;
        #1;
        check("r_drainValid", LW'(drainValid), LW'(0));
        check("r_empty", LW'(empty), LW'(1));
        check("r_hit", LW'(lookupHit), LW'(0));
        drainReady = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        tick();
        drive(1'b1, 28'h0000050, 8'h44, 16'h0001, 1'b0);
        #1;
        check("r_enqReady", LW'(enqueueReady), LW'(1));
        tick();
        enqueueValid = 1'b0;
        #1;
        check("r_postValid", LW'(drainValid), LW'(1));
        check("r_postAddr", LW'(drainAddr), LW'(28'h0000050));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
